// File: rtl/uart_cmd_receiver_if.sv
// Command/response handshake bundle between uart_cmd_receiver (slave side)
// and the command processor that consumes commands and supplies responses (master side).
interface uart_cmd_receiver_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;
  logic        frm_err;

  modport master (
    input  cmd, cmd_rdy, tx_done, frm_err,
    output clr_cmd_rdy, resp, trmt
  );

  modport slave (
    output cmd, cmd_rdy, tx_done, frm_err,
    input  clr_cmd_rdy, resp, trmt
  );
endinterface

// File: rtl/uart_cmd_receiver.sv
// 8N1 UART endpoint: assembles two received bytes (high first) into a 16-bit command
// and sends single response bytes. Define UART_CMD_FRAME_CHK_EN for stop-bit checking.
module uart_cmd_receiver #(
  parameter int BAUD_DIV     = 5208,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX,
  output logic               TX,
  uart_cmd_receiver_if.slave bus
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int TO_W   = $clog2(TIMEOUT_BITS * BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_BITS * BAUD_DIV - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [0:0] WAIT_HI = 1'b0, WAIT_LO = 1'b1;
  localparam logic [0:0] TX_IDLE = 1'b0, TX_XMIT = 1'b1;

  logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              start_edge_s, byte_vld_s, frm_bad_s;
  logic [0:0]        cmd_state_q, cmd_state_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d, frm_err_q, frm_err_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [0:0]        tx_state_q, tx_state_d;
  logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [9:0]        tx_shift_q, tx_shift_d;
  logic              tx_done_q, tx_done_d;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_comb begin
    rx_s1_d   = RX;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
  end

  assign start_edge_s = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_s2_q;

  // Receive engine: start re-check at half a bit, then one sample per bit-time.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld_s = 1'b0;
    frm_bad_s  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (start_edge_s) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + BAUD_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + BAUD_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
`ifdef UART_CMD_FRAME_CHK_EN
          byte_vld_s = rx_s2_q;
          frm_bad_s  = ~rx_s2_q;
`else
          byte_vld_s = 1'b1;
`endif
        end else begin
          rx_cnt_d = rx_cnt_q + BAUD_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Command assembly; a new command's set of cmd_rdy overrides a same-cycle clear.
  always_comb begin
    cmd_state_d = cmd_state_q;
    hi_byte_d   = hi_byte_q;
    cmd_d       = cmd_q;
    to_cnt_d    = to_cnt_q;
    frm_err_d   = frm_bad_s;
    if (bus.clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
    case (cmd_state_q)
      WAIT_HI: begin
        to_cnt_d = '0;
        if (byte_vld_s) begin
          hi_byte_d   = rx_shift_q;
          cmd_state_d = WAIT_LO;
        end else begin
          cmd_state_d = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (frm_bad_s) begin
          cmd_state_d = WAIT_HI;
          hi_byte_d   = 8'h00;
          to_cnt_d    = '0;
        end else if (byte_vld_s) begin
          cmd_d       = {hi_byte_q, rx_shift_q};
          cmd_rdy_d   = 1'b1;
          cmd_state_d = WAIT_HI;
          to_cnt_d    = '0;
        end else if (start_edge_s) begin
          to_cnt_d = '0;
        end else if (rx_state_q != RX_IDLE) begin
          to_cnt_d = to_cnt_q;
        end else if (to_cnt_q == TO_LAST) begin
          cmd_state_d = WAIT_HI;
          hi_byte_d   = 8'h00;
          to_cnt_d    = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end
      default: cmd_state_d = WAIT_HI;
    endcase
  end

  // Transmit engine: LSB of the shift register is the line, stop bit shifts in ones.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.trmt) begin
          tx_shift_d = {1'b1, bus.resp, 1'b0};
          tx_done_d  = 1'b0;
          tx_cnt_d   = '0;
          tx_bit_d   = 4'd0;
          tx_state_d = TX_XMIT;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_XMIT: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + BAUD_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      cmd_state_q <= WAIT_HI;
      hi_byte_q   <= 8'h00;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      to_cnt_q    <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 4'd0;
      tx_shift_q  <= 10'h3FF;
      tx_done_q   <= 1'b0;
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      cmd_state_q <= cmd_state_d;
      hi_byte_q   <= hi_byte_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frm_err_q   <= frm_err_d;
      to_cnt_q    <= to_cnt_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign TX          = tx_shift_q[0];
  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.tx_done = tx_done_q;
  assign bus.frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Self-checking bench for uart_cmd_receiver (BAUD_DIV=16, TIMEOUT_BITS=32); expectations
// come from a byte-level command model. Define UART_CMD_FRAME_CHK_EN to expect frame checking.
module tb_uart_cmd_receiver;
  localparam int BAUD_DIV     = 16;
  localparam int TIMEOUT_BITS = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_line;
  logic tx_line;
  int   checks = 0;
  int   errors = 0;
  int   frm_pulses = 0;
  int   rdy_base = -1;

  logic [15:0] m_cmd;
  logic        m_rdy;
  logic        m_pend;
  logic [7:0]  m_hi;

  uart_cmd_receiver_if bus();

  uart_cmd_receiver #(.BAUD_DIV(BAUD_DIV), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx_line), .TX(tx_line), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.frm_err === 1'b1) frm_pulses <= frm_pulses + 1;

  // Model: a command is the pair of bytes received in order; a long idle line drops a lone high byte.
  task automatic model_reset();
    m_cmd = 16'h0000; m_rdy = 1'b0; m_pend = 1'b0; m_hi = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pend) begin
      m_cmd = {m_hi, b}; m_rdy = 1'b1; m_pend = 1'b0;
    end else begin
      m_hi = b; m_pend = 1'b1;
    end
  endtask

  task automatic model_gap(input int bits);
    if (bits >= TIMEOUT_BITS) m_pend = 1'b0;
  endtask

  // Drives one 8N1 frame; rdy_at is the frame-relative cycle where cmd_rdy is first seen rising.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at, output int rdy_at);
    logic [9:0] bits;
    logic       prev;
    bits   = {stop, b, 1'b0};
    rdy_at = -1;
    prev   = bus.cmd_rdy;
    for (int k = 0; k < 10 * BAUD_DIV; k++) begin
      rx_line = bits[k / BAUD_DIV];
      bus.clr_cmd_rdy = (k == clr_at);
      @(negedge clk);
      if (bus.cmd_rdy === 1'b1 && prev !== 1'b1 && rdy_at < 0) rdy_at = k + 1;
      prev = bus.cmd_rdy;
    end
    bus.clr_cmd_rdy = 1'b0;
    rx_line = 1'b1;
  endtask

  task automatic idle_bits(input int bits);
    rx_line = 1'b1;
    repeat (bits * BAUD_DIV) @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_line = 1'b1; bus.clr_cmd_rdy = 1'b0; bus.trmt = 1'b0; bus.resp = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx_line); end
    checks++; if (bus.cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd got %h exp 0000", bus.cmd); end
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy got %b exp 0", bus.cmd_rdy); end
    checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got %b exp 0", bus.tx_done); end
    checks++; if (bus.frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err got %b exp 0", bus.frm_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int r;
    send_frame(8'h12, 1'b1, -1, r);
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL basic_half_rdy got %b exp 0", bus.cmd_rdy); end
    checks++; if (bus.cmd !== 16'h0000) begin errors++; $display("FAIL basic_half_cmd got %h exp 0000", bus.cmd); end
    send_frame(8'h34, 1'b1, -1, r);
    rdy_base = r;
    checks++; if (r < 150 || r > 158) begin errors++; $display("FAIL basic_rdy_latency got %0d exp 150..158", r); end
    checks++; if (bus.cmd !== 16'h1234) begin errors++; $display("FAIL basic_cmd got %h exp 1234", bus.cmd); end
    idle_bits(4);
    checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy_held got %b exp 1", bus.cmd_rdy); end
    pulse_clr();
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL basic_rdy_clr got %b exp 0", bus.cmd_rdy); end
    checks++; if (bus.cmd !== 16'h1234) begin errors++; $display("FAIL basic_cmd_hold got %h exp 1234", bus.cmd); end
  endtask

  task automatic test_timeout();
    int r;
    send_frame(8'hAB, 1'b1, -1, r);
    idle_bits(33);
    send_frame(8'hCD, 1'b1, -1, r);
    checks++; if (bus.cmd !== 16'h1234) begin errors++; $display("FAIL timeout_cmd_mid got %h exp 1234", bus.cmd); end
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL timeout_rdy_mid got %b exp 0", bus.cmd_rdy); end
    send_frame(8'hEF, 1'b1, -1, r);
    checks++; if (bus.cmd !== 16'hCDEF) begin errors++; $display("FAIL timeout_cmd got %h exp CDEF", bus.cmd); end
    checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL timeout_rdy got %b exp 1", bus.cmd_rdy); end
    pulse_clr();
  endtask

  task automatic test_tx(input logic [7:0] data, input bit retrigger);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    bus.resp = data;
    bus.trmt = 1'b1;
    for (int k = 1; k <= 10 * BAUD_DIV + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.trmt = 1'b0;
        bus.resp = ~data;
      end else if (retrigger && k == 3 * BAUD_DIV) begin
        bus.trmt = 1'b1;
        bus.resp = 8'h00;
      end else begin
        bus.trmt = 1'b0;
      end
      if (k == 2) begin
        checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL tx_done_clear got %b exp 0", bus.tx_done); end
      end
      if (k >= 9 && ((k - 9) % BAUD_DIV) == 0 && (k - 9) / BAUD_DIV < 10) begin
        checks++;
        if (tx_line !== frame[(k - 9) / BAUD_DIV]) begin
          errors++;
          $display("FAIL tx_bit%0d data %h got %b exp %b", (k - 9) / BAUD_DIV, data, tx_line, frame[(k - 9) / BAUD_DIV]);
        end
      end
      if (k == 10 * BAUD_DIV) begin
        checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL tx_done_early got %b exp 0", bus.tx_done); end
      end
      if (k == 10 * BAUD_DIV + 1) begin
        checks++; if (bus.tx_done !== 1'b1) begin errors++; $display("FAIL tx_done_set got %b exp 1", bus.tx_done); end
      end
    end
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL tx_idle got %b exp 1", tx_line); end
  endtask

  task automatic test_glitch();
    int r;
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(3);
    checks++; if (bus.cmd !== 16'hCDEF) begin errors++; $display("FAIL glitch_cmd got %h exp CDEF", bus.cmd); end
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy got %b exp 0", bus.cmd_rdy); end
    send_frame(8'h00, 1'b1, -1, r);
    send_frame(8'h01, 1'b1, -1, r);
    checks++; if (bus.cmd !== 16'h0001) begin errors++; $display("FAIL glitch_pair_cmd got %h exp 0001", bus.cmd); end
    checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL glitch_pair_rdy got %b exp 1", bus.cmd_rdy); end
    pulse_clr();
  endtask

  task automatic test_clr_collision();
    int r;
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL collide_pre_rdy got %b exp 0", bus.cmd_rdy); end
    send_frame(8'h5A, 1'b1, -1, r);
    send_frame(8'hC3, 1'b1, rdy_base - 1, r);
    checks++; if (r !== rdy_base) begin errors++; $display("FAIL collide_rdy_at got %0d exp %0d", r, rdy_base); end
    checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL collide_rdy got %b exp 1", bus.cmd_rdy); end
    checks++; if (bus.cmd !== 16'h5AC3) begin errors++; $display("FAIL collide_cmd got %h exp 5AC3", bus.cmd); end
  endtask

  task automatic test_reset_midframe();
    int r;
    logic [7:0] lo;
    lo = 8'h88;
    send_frame(8'h77, 1'b1, -1, r);
    rx_line = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_line = lo[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rx_line = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", tx_line); end
    checks++; if (bus.cmd !== 16'h0000) begin errors++; $display("FAIL midrst_cmd got %h exp 0000", bus.cmd); end
    checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got %b exp 0", bus.cmd_rdy); end
    checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL midrst_tx_done got %b exp 0", bus.tx_done); end
    checks++; if (bus.frm_err !== 1'b0) begin errors++; $display("FAIL midrst_frm_err got %b exp 0", bus.frm_err); end
    idle_bits(2);
    send_frame(8'h9A, 1'b1, -1, r);
    send_frame(8'hBC, 1'b1, -1, r);
    checks++; if (bus.cmd !== 16'h9ABC) begin errors++; $display("FAIL midrst_pair_cmd got %h exp 9ABC", bus.cmd); end
    checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL midrst_pair_rdy got %b exp 1", bus.cmd_rdy); end
    pulse_clr();
  endtask

  task automatic test_frame_err();
    int r;
    int p0;
    logic [15:0] exp_cmd;
    int exp_pulses;
`ifdef UART_CMD_FRAME_CHK_EN
    exp_cmd = 16'h6677; exp_pulses = 1;
`else
    exp_cmd = 16'h5566; exp_pulses = 0;
`endif
    p0 = frm_pulses;
    send_frame(8'h55, 1'b0, -1, r);
    idle_bits(2);
    send_frame(8'h66, 1'b1, -1, r);
    send_frame(8'h77, 1'b1, -1, r);
    checks++; if (frm_pulses - p0 !== exp_pulses) begin errors++; $display("FAIL frm_err_pulses got %0d exp %0d", frm_pulses - p0, exp_pulses); end
    checks++; if (bus.cmd !== exp_cmd) begin errors++; $display("FAIL frm_cmd got %h exp %h", bus.cmd, exp_cmd); end
    checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL frm_rdy got %b exp 1", bus.cmd_rdy); end
  endtask

  task automatic test_random();
    int r;
    int gap;
    logic [7:0] b;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    for (int it = 0; it < 20; it++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, -1, r);
      model_byte(b);
      checks++; if (bus.cmd !== m_cmd) begin errors++; $display("FAIL rand%0d_cmd got %h exp %h", it, bus.cmd, m_cmd); end
      checks++; if (bus.cmd_rdy !== m_rdy) begin errors++; $display("FAIL rand%0d_rdy got %b exp %b", it, bus.cmd_rdy, m_rdy); end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_rdy = 1'b0;
      end
      gap = ($urandom_range(0, 7) == 0) ? 34 : $urandom_range(0, 3);
      idle_bits(gap);
      model_gap(gap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_tx(8'hA5, 1'b1);
    test_tx(8'($urandom_range(0, 255)), 1'b0);
    test_glitch();
    test_clr_collision();
    test_reset_midframe();
    test_frame_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_receiver.md
Name: uart_cmd_receiver

Overview:
- DUT-side end of the two-byte serial command link.
- Receives a 16-bit command over a UART line as two 8N1 bytes, high byte first, and presents the assembled word with a ready flag.
- Transmits single 8-bit response bytes back on TX.
- Self-contained: own baud-rate RX and TX engines plus a command-assembly FSM; sits between the RX/TX pins and the command processor.

Parameters:
- BAUD_DIV, 5208: clocks per bit (50 MHz / 9600 baud); must be ≥ 4 and even.
- TIMEOUT_BITS, 32: bit-times allowed between the high-byte stop sample and the low-byte start edge before the high byte is discarded.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- RX  input  1  serial data in, asynchronous, idle high
- TX  output  1  serial data out, idle high
- cmd  output  16  assembled command
- cmd_rdy  output  1  cmd valid, held until cleared
- clr_cmd_rdy  input  1  consumer acknowledge of cmd
- resp  input  8  response byte to send
- trmt  input  1  single-cycle request to send resp
- tx_done  output  1  response byte fully sent, held until next accepted trmt
- frm_err  output  1  single-cycle pulse on bad stop bit (only with macro)

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled on posedge clk only).
  - TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0, frm_err=0.
  - RX synchronizer flops preset to 1; both engines and FSM return to their idle states.
  - Reset mid-frame abandons the frame, with no partial byte or cmd update.
- RX engine (states IDLE, START, DATA, STOP):
  - RX passes through 2 flops; a falling edge on the synchronized RX in IDLE enters START.
  - Start bit is re-sampled at BAUD_DIV/2 clocks; if it reads 1, return to IDLE (glitch reject).
  - 8 data bits are sampled every BAUD_DIV clocks, LSB first, then the stop bit one bit-time later.
  - On the stop sample, byte_vld pulses internally for 1 cycle and the engine returns to IDLE.
  - A new start edge is accepted from the cycle after the stop sample.
- Command FSM (states WAIT_HI, WAIT_LO):
  - WAIT_HI: byte_vld stores the byte in hi_byte and moves to WAIT_LO.
  - WAIT_LO: byte_vld updates cmd as {hi_byte, byte}, atomically, in the same cycle; cmd_rdy sets the next cycle (latency 1 clk after the stop sample); return to WAIT_HI.
  - cmd holds its value until the next complete command; it never shows a half-updated word.
  - Timeout: in WAIT_LO, a counter runs while RX is idle. Reaching TIMEOUT_BITS×BAUD_DIV clocks discards hi_byte and returns to WAIT_HI. The counter clears on any start edge.
- cmd_rdy handling:
  - Cleared by clr_cmd_rdy.
  - If a set and a clear occur in the same cycle, the set wins.
  - A new command arriving while cmd_rdy=1 overwrites cmd, and cmd_rdy stays 1.
- TX engine (states IDLE, XMIT):
  - trmt in IDLE loads {1, resp, 0} into a 10-bit shift register, clears tx_done, and enters XMIT.
  - TX drives the start bit the cycle after trmt; each bit lasts BAUD_DIV clocks.
  - After the 10th bit-time, return to IDLE and set tx_done.
  - trmt while in XMIT is ignored; resp is captured only at acceptance.
- The RX and TX engines are fully independent, so full-duplex operation is allowed.

Optional Feature:
- Macro UART_CMD_FRAME_CHK_EN.
- Defined: a stop bit sampled as 0 suppresses byte_vld, pulses frm_err for 1 cycle, and forces the FSM to WAIT_HI, discarding any hi_byte.
- Undefined: the stop bit value is ignored, every frame produces byte_vld, and frm_err is tied 0.

Test Plan (BAUD_DIV=16, TIMEOUT_BITS=32):
- Send bytes 0x12 then 0x34 -> cmd=16'h1234 and cmd_rdy=1 exactly 1 clk after the second stop sample; cmd_rdy stays 1 until clr_cmd_rdy, then 0.
- Send 0xAB, idle for 33 bit-times, then send 0xCD, 0xEF -> cmd=16'hCDEF; 0xAB is never visible on cmd.
- Pulse trmt with resp=0xA5 -> TX shows 0, 1,0,1,0,0,1,0,1, then 1, each bit 16 clks; tx_done=1 after 160 clks; a second trmt during XMIT is ignored.
- 4-clk low glitch on RX -> no byte_vld, cmd and FSM unchanged; a following 0x00, 0x01 pair gives cmd=16'h0001.
- clr_cmd_rdy asserted in the same cycle cmd_rdy sets -> cmd_rdy=1; assert rst_n=0 midway through a low byte -> all outputs at reset values, and the next full pair is assembled correctly.
- With UART_CMD_FRAME_CHK_EN, send 0x55 with stop=0, then 0x66, 0x77 -> frm_err pulses once, cmd=16'h6677; without the macro, the same stimulus gives cmd=16'h5566.
